fifo_param_sync: RTL

- Parametrised single-clock synchronous FIFO; successor to the fixed-size FIFO DUT in the FIFO verification environment.
- Adds configurable width and depth, programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and a first-word-fall-through (FWFT) read mode.
- Sits behind the FIFO interface bundle as the DUT, driven by the bench and observed by the monitor.

---
 rtl/fifo_param_sync_pkg.sv | 16 +
 rtl/fifo_param_sync_mem.sv | 28 ++
 rtl/fifo_param_sync.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fifo_param_sync_pkg.sv
// Shared defaults and operation encoding for the parametrised FIFO and its bench.
package fifo_param_sync_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 16;
  localparam int          FIFO_DEPTH      = 8;

  // Operation applied to the FIFO in one cycle, as driven by bench and seen by monitor
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_WR,
    OP_RD,
    OP_WR_RD,
    OP_FLUSH
  } fifo_op_e;

endpackage

// File: rtl/fifo_param_sync_mem.sv
// Storage array: one synchronous write port, one asynchronous read port.
module fifo_param_sync_mem
  import fifo_param_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int          DEPTH      = FIFO_DEPTH,
  parameter int unsigned PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents deliberately survive reset and flush
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_param_sync.sv
// Parametrised single-clock FIFO with thresholds, occupancy count, flush and optional FWFT read.
module fifo_param_sync
  import fifo_param_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int          DEPTH      = FIFO_DEPTH,
  parameter int          AF_THRESH  = DEPTH - 1,
  parameter int          AE_THRESH  = 1,
  parameter int          FWFT       = 0,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);

  // Reject illegal configurations at elaboration
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_param_sync: DEPTH must be >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("fifo_param_sync: AF_THRESH must be in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("fifo_param_sync: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full        = (count_q == CNT_FULL);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= CNT_AF);
  assign almostempty = (count_q <= CNT_AE);
  assign wr_acc      = wr_en & ~full & ~flush;
  assign rd_acc      = rd_en & ~empty & ~flush;

  fifo_param_sync_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Next-state for pointers, occupancy, read register and status pulses
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    wr_ack_d    = wr_acc;
    overflow_d  = wr_en & full & ~flush;
    underflow_d = rd_en & empty & ~flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (rd_acc) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        dout_d   = rd_data;
      end
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // FWFT shows the head word directly; otherwise the registered read word
  assign data_out  = (FWFT != 0) ? (empty ? '0 : rd_data) : dout_q;
  assign count     = count_q;
  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
